// File: rtl/sopc_v3_cmd_out_if.sv
// sopc_v3_cmd_out_if: Avalon-MM slave bus plus command valid/ready handshake for sopc_v3_cmd_out
interface sopc_v3_cmd_out_if #(parameter int DATA_WIDTH = 32);
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [DATA_WIDTH-1:0] out_port;
  logic out_valid;
  logic out_ready;
  logic irq;
  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input readdata, out_port, out_valid, irq
  );
  modport slave (
    input address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid, irq
  );
endinterface

// File: rtl/sopc_v3_cmd_out.sv
// sopc_v3_cmd_out: Avalon-MM command output port with valid/ready handshake, sticky status and count.
// Define SOPC_V3_CMD_OUT_IRQ_EN to include the CONTROL register and the completion interrupt.
module sopc_v3_cmd_out #(
  parameter int DATA_WIDTH = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input logic clk,
  input logic reset_n,
  sopc_v3_cmd_out_if.slave bus
);
  logic [DATA_WIDTH-1:0] data_q;
  logic valid_q;
  logic ovf_q;
  logic done_q;
  logic [15:0] count_q;
  logic [31:0] readdata_q;
  logic [31:0] rd_mux;
  logic irq_en;
  logic wr;
  logic data_wr;
  logic status_wr;
  logic hs;
  logic accept;
  logic ovf_set;
  logic unused_wdata;
  assign wr = bus.chipselect & ~bus.write_n;
  assign data_wr = wr & (bus.address == 2'd0);
  assign status_wr = wr & (bus.address == 2'd1);
  assign hs = valid_q & bus.out_ready;
  // a handshake in the same cycle frees the slot, so back-to-back writes are accepted
  assign accept = data_wr & (~valid_q | bus.out_ready);
  assign ovf_set = data_wr & valid_q & ~bus.out_ready;
  assign rd_mux = bus.address == 2'd0 ? 32'(data_q) :
                  bus.address == 2'd1 ? {29'b0, done_q, ovf_q, valid_q} :
                  bus.address == 2'd2 ? {31'b0, irq_en} :
                                        {16'b0, count_q};
  assign unused_wdata = ^bus.writedata;
  assign bus.out_port = data_q;
  assign bus.out_valid = valid_q;
  assign bus.readdata = readdata_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE[DATA_WIDTH-1:0];
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      count_q <= 16'h0;
      readdata_q <= 32'h0;
    end else begin
      readdata_q <= rd_mux;
      if (accept) data_q <= bus.writedata[DATA_WIDTH-1:0];
      valid_q <= accept | (valid_q & ~bus.out_ready);
      ovf_q <= ovf_set | (ovf_q & ~(status_wr & bus.writedata[1]));
      done_q <= hs | (done_q & ~(status_wr & bus.writedata[2]));
      count_q <= count_q + 16'(hs);
    end
  end
`ifdef SOPC_V3_CMD_OUT_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr && bus.address == 2'd2) irq_en <= bus.writedata[0];
      irq_q <= irq_en & done_q;
    end
  end
  assign bus.irq = irq_q;
`else
  assign irq_en = 1'b0;
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_sopc_v3_cmd_out.sv
// tb_sopc_v3_cmd_out: directed and randomized checks of sopc_v3_cmd_out against a queue-based reference model
module tb_sopc_v3_cmd_out;
  localparam int DW = 32;
  localparam logic [31:0] RV = 32'h5A5A_0001;
`ifdef SOPC_V3_CMD_OUT_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int passes = 0;
  int total = 0;
  always #5 clk = ~clk;
  sopc_v3_cmd_out_if #(.DATA_WIDTH(DW)) bus ();
  sopc_v3_cmd_out #(.DATA_WIDTH(DW), .RESET_VALUE(RV)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b1;
    step();
    bus.chipselect = 1'b0;
    v = bus.readdata;
  endtask
  // reference model: at most one pending command, plus the spec's flag and counter rules
  logic [31:0] q[$];
  logic [31:0] m_last;
  logic m_ovf, m_done, m_en, hs, ovf_set, exp_irq;
  logic [15:0] m_count;
  logic [31:0] v, wd, exp_rd;
  logic [1:0] a;
  logic cs, wn;
  int op;
  initial begin
    logic [31:0] rst_exp [4];
    rst_exp = '{RV, 32'h0, 32'h0, 32'h0};
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_port", bus.out_port, RV);
    check("rst_readdata", bus.readdata, 0);
    check("rst_irq", bus.irq, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check($sformatf("rst_read%0d", i), v, rst_exp[i]);
    end
    // single command held until the consumer is ready
    wr(2'd0, 32'h1234_5678);
    check("hold_valid0", bus.out_valid, 1);
    check("hold_port0", bus.out_port, 32'h1234_5678);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("hold_valid%0d", i), bus.out_valid, 1);
      check($sformatf("hold_port%0d", i), bus.out_port, 32'h1234_5678);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("hs_valid", bus.out_valid, 0);
    rd(2'd1, v); check("hs_status", v, 32'h4);
    rd(2'd3, v); check("hs_count", v, 32'h1);
    // overflow while busy, then W1C
    wr(2'd1, 32'h4);
    wr(2'd0, 32'h1111_2222);
    wr(2'd0, 32'hAAAA_5555);
    check("ovf_port", bus.out_port, 32'h1111_2222);
    rd(2'd1, v); check("ovf_status", v, 32'h3);
    wr(2'd1, 32'h2);
    rd(2'd1, v); check("ovf_clr_status", v, 32'h1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    wr(2'd1, 32'h4);
    rd(2'd1, v); check("idle_status", v, 32'h0);
    // back-to-back at one command per cycle
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.address = 2'd0;
      bus.writedata = 32'(i);
      bus.chipselect = 1'b1;
      bus.write_n = 1'b0;
      step();
      check($sformatf("b2b_port%0d", i), bus.out_port, 32'(i));
      check($sformatf("b2b_valid%0d", i), bus.out_valid, 1);
    end
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("b2b_drain_valid", bus.out_valid, 0);
    rd(2'd3, v); check("b2b_count", v, 32'd6);
    rd(2'd1, v); check("b2b_status", v, 32'h4);
    // clearing done in the handshake cycle: the set wins
    wr(2'd0, 32'h77);
    bus.out_ready = 1'b1;
    wr(2'd1, 32'h4);
    bus.out_ready = 1'b0;
    rd(2'd1, v); check("setwins_status", v, 32'h4);
    // interrupt
    wr(2'd2, 32'h1);
    rd(2'd2, v); check("ctrl_read", v, 32'(IRQ_BUILD));
    wr(2'd1, 32'h4);
    step();
    check("irq_idle", bus.irq, 0);
    wr(2'd0, 32'h0000_BEEF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("irq_at_done", bus.irq, 0);
    step();
    check("irq_after_done", bus.irq, 1'(IRQ_BUILD));
    wr(2'd1, 32'h4);
    check("irq_clr_edge", bus.irq, 1'(IRQ_BUILD));
    step();
    check("irq_cleared", bus.irq, 0);
    // randomized phase against the reference model
    m_last = 32'h0000_BEEF;
    m_ovf = 1'b0;
    m_done = 1'b0;
    m_en = IRQ_BUILD;
    m_count = 16'd8;
    for (int c = 0; c < 3000; c++) begin
      op = int'($urandom_range(0, 9));
      wd = $urandom;
      a = op < 4 ? 2'd0 : op == 4 ? 2'd1 : op == 5 ? 2'd3 : op == 6 ? 2'd2 : 2'($urandom_range(0, 3));
      wn = op > 6;
      cs = op <= 6 ? 1'b1 : 1'($urandom_range(0, 1));
      bus.address = a;
      bus.writedata = wd;
      bus.chipselect = cs;
      bus.write_n = wn;
      bus.out_ready = 1'($urandom_range(0, 1));
      exp_rd = a == 2'd0 ? m_last : a == 2'd1 ? {29'b0, m_done, m_ovf, q.size() != 0} :
               a == 2'd2 ? {31'b0, m_en} : {16'b0, m_count};
      exp_irq = m_en & m_done;
      hs = q.size() != 0 && bus.out_ready;
      ovf_set = 1'b0;
      if (hs) begin
        void'(q.pop_front());
        m_count = m_count + 16'd1;
      end
      if (cs && !wn) begin
        if (a == 2'd0) begin
          if (q.size() == 0) begin
            q.push_back(wd);
            m_last = wd;
          end else ovf_set = 1'b1;
        end else if (a == 2'd1) begin
          if (wd[1]) m_ovf = 1'b0;
          if (wd[2]) m_done = 1'b0;
        end else if (a == 2'd2 && IRQ_BUILD) m_en = wd[0];
      end
      if (ovf_set) m_ovf = 1'b1;
      if (hs) m_done = 1'b1;
      step();
      check("rnd_valid", bus.out_valid, q.size() != 0);
      check("rnd_port", bus.out_port, m_last);
      check("rnd_readdata", bus.readdata, exp_rd);
      check("rnd_irq", bus.irq, exp_irq);
    end
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    // COUNT from 0 up to 0xFFFF, then wrap
    bus.out_ready = 1'b1;
    bus.address = 2'd0;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      bus.writedata = 32'(i);
      step();
    end
    bus.address = 2'd3;
    bus.write_n = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.chipselect = 1'b0;
    check("bulk_count", bus.readdata, 32'hFFFF);
    check("bulk_port", bus.out_port, 32'hFFFF);
    check("bulk_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wr(2'd0, 32'h0000_CAFE);
    bus.out_ready = 1'b0;
    rd(2'd3, v); check("wrap_count", v, 32'h0);
    rd(2'd1, v); check("wrap_status", v, 32'h5);
    check("wrap_port", bus.out_port, 32'h0000_CAFE);
    bus.out_ready = 1'b1;
    wr(2'd0, 32'h0000_D00D);
    bus.out_ready = 1'b0;
    check("pre_rst_valid", bus.out_valid, 1);
    // asynchronous reset mid-transfer
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_port", bus.out_port, RV);
    check("async_readdata", bus.readdata, 0);
    check("async_irq", bus.irq, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd3, v); check("post_rst_count", v, 32'h0);
    rd(2'd0, v); check("post_rst_data", v, RV);
    rd(2'd1, v); check("post_rst_status", v, 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/sopc_v3_cmd_out.md
# sopc_v3_cmd_out

Avalon-MM slave output port for the SOPC v3 system, the write-direction counterpart of the polled input ports. The Nios II software writes a command word, and the block presents it on `out_port` with a valid/ready handshake toward the downstream actuator logic. The block reports busy, overflow, done and transfer count back over the same slave, and can optionally raise an interrupt on completion.

## Interface
- `DATA_WIDTH`, 32: width of `out_port`; legal range 1..32.
- `RESET_VALUE`, 0: value of the data register, and so of `out_port`, after reset.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `address`  in  2  register select, word addressed.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect`=1 and `write_n`=0.
- `writedata`  in  32  write data; only bits [DATA_WIDTH-1:0] are used for DATA.
- `readdata`  out  32  registered read data, zero-extended.
- `out_port`  out  DATA_WIDTH  command word to downstream logic.
- `out_valid`  out  1  `out_port` holds an unconsumed command.
- `out_ready`  in  1  downstream accepts the command.
- `irq`  out  1  interrupt request; level, active-high.

## Operation
- Register map:
  - addr 0, DATA (R/W): read returns the data register.
  - addr 1, STATUS: bit0 busy (= `out_valid`, read-only); bit1 overflow (sticky, write-1-to-clear); bit2 done (sticky, write-1-to-clear).
  - addr 2, CONTROL (R/W): bit0 irq_en.
  - addr 3, COUNT (RO): [15:0] count of completed handshakes; wraps 0xFFFF->0.
- Write to DATA while idle (`out_valid`=0):
  - data register <= writedata[DATA_WIDTH-1:0].
  - `out_valid` <= 1.
- Handshake: completes in a cycle where `out_valid`=1 and `out_ready`=1. Next cycle:
  - `out_valid`=0, unless a new DATA write happens in the same cycle.
  - done=1.
  - COUNT+1.
- Write to DATA while `out_valid`=1 and `out_ready`=0: the write is dropped; data register unchanged; overflow<=1.
- Write to DATA in the same cycle as a handshake completes: the write is accepted and the new data is loaded. `out_valid` stays 1, done is set, COUNT increments. This is back-to-back operation.
- `out_port` is driven directly from the data register; it is stable while `out_valid`=1.
- `out_ready` is ignored while `out_valid`=0.
- Sticky flags: if a W1C and a set event occur in the same cycle, the set wins.
- Writes to addr 3 and to the read-only STATUS bits are ignored.
- `irq` = irq_en & done, registered.
- Reset values:
  - `readdata`=0, data register=RESET_VALUE, `out_valid`=0.
  - overflow, done, irq_en = 0; COUNT=0; `irq`=0.
- Reset mid-transfer: `out_valid` drops asynchronously and the pending command is discarded.

## Timing
- Read latency is 1 cycle: `readdata` <= mux(`address`) on every clock edge, independent of `chipselect`. There are no wait states.
- Write to `out_valid`: the DATA write is sampled at edge N, and `out_port`/`out_valid` update after edge N.
- Handshake sampled at edge N: `out_valid` low and done/COUNT updated after edge N. A STATUS/COUNT read issued at edge N+1 returns the updated values after edge N+1.
- Done to `irq`: 1 cycle.
- Sustained throughput is one command per cycle when `out_ready` is held high and DATA is written every cycle.

## Configuration
- `SOPC_V3_CMD_OUT_IRQ_EN`
  - Defined: the CONTROL register and the `irq` logic are present as described above.
  - Undefined: addr 2 reads 0 and writes to it are ignored; `irq` is tied to 0. The done flag and COUNT still operate.

## Test plan
- Reset, then read addrs 0-3 -> `readdata` = RESET_VALUE, 0, 0, 0 one cycle after each read; `out_valid`=0.
- Write DATA=0x12345678 with `out_ready`=0, then hold 3 cycles, then raise `out_ready` -> `out_port`=0x12345678 and `out_valid`=1 until the handshake; then `out_valid`=0, STATUS=0x4, COUNT=1.
- While busy with `out_ready`=0, write DATA=0xAAAA5555 -> `out_port` unchanged, STATUS=0x3; write STATUS=0x2 -> STATUS=0x1.
- With `out_ready`=1, write DATA every cycle for 4 cycles (values 1..4) -> each value is presented for one cycle, COUNT=4, no overflow.
- IRQ build: write CONTROL=1, complete one handshake -> `irq`=1 one cycle after done. Write STATUS=0x4 -> `irq`=0. Non-IRQ build: same stimulus keeps `irq`=0 and addr 2 reads 0.
- Assert `reset_n` while `out_valid`=1 and COUNT=0xFFFF -> `out_valid`=0, COUNT=0, `out_port`=RESET_VALUE immediately. In a separate run, 0x10000 handshakes from 0 -> COUNT wraps to 0.
